// File: rtl/sonuc_bcd_cevirici_pkg.sv
// Shared definitions for the Q32.32 result to BCD converter.
//   - FSM state encodings
//   - Q32.32 field bounds (integer part [63:32], fraction [31:0])
//   - BCD accumulator width and bit-counter width
package sonuc_bcd_cevirici_pkg;

  localparam int TAM_W     = 32;          // integer bits converted
  localparam int BASAMAK   = 10;          // BCD digits, 10**10 > 2**32
  localparam int BCD_W     = 4 * BASAMAK; // packed BCD width
  localparam int TAM_MSB   = 63;
  localparam int TAM_LSB   = 32;
  localparam int KESIR_MSB = 31;
  localparam int SAYAC_W   = 6;           // bit counter, holds 0..TAM_W-1

  typedef enum logic [1:0] {
    BOS      = 2'd0,  // idle, accepting input
    DONUSTUR = 2'd1,  // double-dabble in progress, one bit per clock
    SUN      = 2'd2   // result presented, waiting for downstream
  } durum_t;

endpackage

// File: rtl/sonuc_bcd_cevirici_duzelt.sv
// Double-dabble digit correction: one BCD digit, add 3 when >= 5.
// Ports:
//   giris  in  4  current digit
//   cikis  out 4  corrected digit (never overflows 4 bits for a valid digit)
module bcd_basamak_duzelt (
  input  logic [3:0] giris,
  output logic [3:0] cikis
);

  assign cikis = (giris >= 4'd5) ? (giris + 4'd3) : giris;

endmodule

// File: rtl/sonuc_bcd_cevirici.sv
// Converts the unsigned integer part of a Q32.32 result word into 10 packed
// BCD digits using sequential double-dabble (one bit per clock) and hands
// digits plus the raw fraction to the next stage.
//
// Handshake: input transfer happens on a rising edge where giris_gecerli=1
// and hazir=1; output transfer happens on a rising edge where
// cikis_gecerli=1 and cikis_hazir=1. Outputs hold steady while
// cikis_gecerli=1 and cikis_hazir=0. All outputs come straight from
// registers; none depends combinationally on an input.
//
// Ports:
//   clk            in   1   clock, rising edge
//   rst_n          in   1   asynchronous active-low reset
//   sonuc          in   64  Q32.32 result word
//   tasma          in   1   overflow flag of sonuc
//   giris_gecerli  in   1   sonuc/tasma valid
//   hazir          out  1   idle, accepts input
//   bcd            out  40  packed BCD, digit 9 at [39:36]
//   kesir          out  32  fraction bits sonuc[31:0]
//   hata           out  1   overflowed result, bcd forced to 0
//   cikis_gecerli  out  1   bcd/kesir/hata valid
//   cikis_hazir    in   1   downstream accepts output
//   dbg_durum      out  2   current FSM state (debug visibility)
module sonuc_bcd_cevirici
  import sonuc_bcd_cevirici_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic [63:0]        sonuc,
  input  logic               tasma,
  input  logic               giris_gecerli,
  output logic               hazir,
  output logic [BCD_W-1:0]   bcd,
  output logic [KESIR_MSB:0] kesir,
  output logic               hata,
  output logic               cikis_gecerli,
  input  logic               cikis_hazir,
  output logic [1:0]         dbg_durum
);

  durum_t             durum;
  logic [SAYAC_W-1:0] sayac;
  logic [TAM_W-1:0]   kaydirma;
  logic [BCD_W-1:0]   acc;
  logic [BCD_W-1:0]   duz;
  logic [KESIR_MSB:0] kesir_r;
  logic               hata_r;

  // Add-3 correction on every digit in parallel; digits are independent.
  for (genvar g = 0; g < BASAMAK; g++) begin : g_duzelt
    bcd_basamak_duzelt u_duzelt (
      .giris (acc[4*g +: 4]),
      .cikis (duz[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      durum    <= BOS;
      sayac    <= '0;
      kaydirma <= '0;
      acc      <= '0;
      kesir_r  <= '0;
      hata_r   <= 1'b0;
    end else begin
      case (durum)
        BOS: begin
          if (giris_gecerli) begin
            kaydirma <= sonuc[TAM_MSB:TAM_LSB];
            kesir_r  <= sonuc[KESIR_MSB:0];
            hata_r   <= tasma;
            acc      <= '0;
            sayac    <= '0;
            // Overflowed results skip conversion; bcd stays cleared.
            durum    <= tasma ? SUN : DONUSTUR;
          end
        end
        DONUSTUR: begin
          // {bcd, shift} shifted left once after correction.
          acc      <= {duz[BCD_W-2:0], kaydirma[TAM_W-1]};
          kaydirma <= {kaydirma[TAM_W-2:0], 1'b0};
          if (sayac == SAYAC_W'(TAM_W - 1)) begin
            sayac <= '0;
            durum <= SUN;
          end else begin
            sayac <= sayac + 1'b1;
          end
        end
        SUN: begin
          if (cikis_hazir) durum <= BOS;
        end
        default: durum <= BOS;
      endcase
    end
  end

  assign hazir         = (durum == BOS);
  assign cikis_gecerli = (durum == SUN);
  assign bcd           = acc;
  assign kesir         = kesir_r;
  assign hata          = hata_r;
  assign dbg_durum     = durum;

endmodule

// File: tb/tb_sonuc_bcd_cevirici.sv
module tb_sonuc_bcd_cevirici;

  logic        clk;
  logic        rst_n;
  logic [63:0] sonuc;
  logic        tasma;
  logic        giris_gecerli;
  logic        hazir;
  logic [39:0] bcd;
  logic [31:0] kesir;
  logic        hata;
  logic        cikis_gecerli;
  logic        cikis_hazir;
  logic [1:0]  dbg_durum;

  int checks   = 0;
  int failures = 0;

  logic [39:0] exp_q[$];

  sonuc_bcd_cevirici dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .sonuc         (sonuc),
    .tasma         (tasma),
    .giris_gecerli (giris_gecerli),
    .hazir         (hazir),
    .bcd           (bcd),
    .kesir         (kesir),
    .hata          (hata),
    .cikis_gecerli (cikis_gecerli),
    .cikis_hazir   (cikis_hazir),
    .dbg_durum     (dbg_durum)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------- vector table ----------------
  typedef struct {
    logic [63:0] sonuc;
    logic        tasma;
    logic [39:0] bcd;
    logic [31:0] kesir;
    logic        hata;
    int          lat;   // edges after the accept edge until cikis_gecerli
  } vec_t;

  vec_t vecs[10];

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Full transaction: accept, wait for result, check, hand off.
  task automatic run_vec(input vec_t v, input int n);
    int lat;
    @(negedge clk);
    check($sformatf("v%0d_hazir_before", n), {63'd0, hazir}, 64'd1);
    sonuc = v.sonuc; tasma = v.tasma; giris_gecerli = 1'b1; cikis_hazir = 1'b0;
    @(posedge clk); #1;
    giris_gecerli = 1'b0;
    check($sformatf("v%0d_hazir_busy", n), {63'd0, hazir}, 64'd0);
    lat = 0;
    while (!cikis_gecerli && lat < 100) begin
      @(posedge clk); #1;
      lat++;
    end
    check($sformatf("v%0d_latency", n), 64'(lat), 64'(v.lat));
    check($sformatf("v%0d_bcd", n), {24'd0, bcd}, {24'd0, v.bcd});
    check($sformatf("v%0d_kesir", n), {32'd0, kesir}, {32'd0, v.kesir});
    check($sformatf("v%0d_hata", n), {63'd0, hata}, {63'd0, v.hata});
    cikis_hazir = 1'b1;
    @(posedge clk); #1;
    cikis_hazir = 1'b0;
    check($sformatf("v%0d_hazir_after", n), {63'd0, hazir}, 64'd1);
    check($sformatf("v%0d_gecerli_after", n), {63'd0, cikis_gecerli}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    vecs[0] = '{64'h00003039_80000000, 1'b0, 40'h0000012345, 32'h80000000, 1'b0, 32};
    vecs[1] = '{64'hFFFFFFFF_00000000, 1'b0, 40'h4294967295, 32'h00000000, 1'b0, 32};
    vecs[2] = '{64'h00000000_00000000, 1'b0, 40'h0000000000, 32'h00000000, 1'b0, 32};
    vecs[3] = '{64'h00000001_DEADBEEF, 1'b0, 40'h0000000001, 32'hDEADBEEF, 1'b0, 32};
    vecs[4] = '{64'h00012345_00000000, 1'b1, 40'h0000000000, 32'h00000000, 1'b1, 0};
    vecs[5] = '{64'h3B9ACA00_12345678, 1'b0, 40'h1000000000, 32'h12345678, 1'b0, 32};
    vecs[6] = '{64'h000F4240_00000001, 1'b0, 40'h0001000000, 32'h00000001, 1'b0, 32};
    vecs[7] = '{64'h7FFFFFFF_FFFFFFFF, 1'b0, 40'h2147483647, 32'hFFFFFFFF, 1'b0, 32};
    vecs[8] = '{64'hFFFFFFFF_AAAAAAAA, 1'b1, 40'h0000000000, 32'hAAAAAAAA, 1'b1, 0};
    vecs[9] = '{64'h00000063_00000000, 1'b0, 40'h0000000099, 32'h00000000, 1'b0, 32};

    rst_n = 1'b0; sonuc = '0; tasma = 1'b0; giris_gecerli = 1'b0; cikis_hazir = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_hazir", {63'd0, hazir}, 64'd1);
    check("reset_gecerli", {63'd0, cikis_gecerli}, 64'd0);
    check("reset_bcd", {24'd0, bcd}, 64'd0);
    check("reset_kesir", {32'd0, kesir}, 64'd0);
    check("reset_hata", {63'd0, hata}, 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 10; i++) run_vec(vecs[i], i);

    // ---- stall in SUN: outputs stable, extra input ignored ----
    begin
      int lat;
      @(negedge clk);
      sonuc = 64'h00003039_80000000; tasma = 1'b0; giris_gecerli = 1'b1; cikis_hazir = 1'b0;
      @(posedge clk); #1;
      giris_gecerli = 1'b0;
      lat = 0;
      while (!cikis_gecerli && lat < 100) begin
        @(posedge clk); #1;
        lat++;
      end
      check("stall_latency", 64'(lat), 64'd32);
      // A second request during the stall must not be taken.
      sonuc = 64'h000F4240_11111111; giris_gecerli = 1'b1;
      for (int c = 0; c < 10; c++) begin
        @(posedge clk); #1;
        check($sformatf("stall_c%0d_gecerli", c), {63'd0, cikis_gecerli}, 64'd1);
        check($sformatf("stall_c%0d_hazir", c), {63'd0, hazir}, 64'd0);
        check($sformatf("stall_c%0d_bcd", c), {24'd0, bcd}, 64'h12345);
        check($sformatf("stall_c%0d_kesir", c), {32'd0, kesir}, 64'h80000000);
      end
      giris_gecerli = 1'b0;
      cikis_hazir = 1'b1;
      @(posedge clk); #1;
      cikis_hazir = 1'b0;
      check("stall_release_hazir", {63'd0, hazir}, 64'd1);
      check("stall_release_gecerli", {63'd0, cikis_gecerli}, 64'd0);
      // Nothing was captured while stalled: no further result appears.
      lat = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (cikis_gecerli) lat++;
      end
      check("stall_no_ghost", 64'(lat), 64'd0);
    end

    // ---- reset during conversion at counter=15 ----
    begin
      int seen;
      @(negedge clk);
      sonuc = 64'hFFFFFFFF_CAFEF00D; tasma = 1'b0; giris_gecerli = 1'b1;
      @(posedge clk); #1;
      giris_gecerli = 1'b0;
      repeat (15) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check("midrst_hazir", {63'd0, hazir}, 64'd1);
      check("midrst_gecerli", {63'd0, cikis_gecerli}, 64'd0);
      check("midrst_bcd", {24'd0, bcd}, 64'd0);
      check("midrst_kesir", {32'd0, kesir}, 64'd0);
      check("midrst_hata", {63'd0, hata}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      seen = 0;
      for (int c = 0; c < 40; c++) begin
        @(posedge clk); #1;
        if (cikis_gecerli) seen++;
      end
      check("midrst_no_pulse", 64'(seen), 64'd0);
      run_vec(vecs[7], 100);
    end

    // ---- back-to-back with valid held high ----
    begin
      logic [63:0] vals[3];
      logic [39:0] exps[3];
      logic [39:0] got;
      int idx, outs, last_cyc, cyc;
      logic acc;
      vals[0] = 64'h00003039_00000000; exps[0] = 40'h0000012345;
      vals[1] = 64'h3B9ACA00_00000000; exps[1] = 40'h1000000000;
      vals[2] = 64'h00000063_00000000; exps[2] = 40'h0000000099;
      @(negedge clk);
      idx = 0; outs = 0; last_cyc = -1; cyc = 0;
      sonuc = vals[0]; tasma = 1'b0; giris_gecerli = 1'b1; cikis_hazir = 1'b1;
      exp_q.push_back(exps[0]);
      while (outs < 3 && cyc < 300) begin
        acc = hazir && giris_gecerli;
        @(posedge clk); #1;
        cyc++;
        if (acc) begin
          idx++;
          if (idx < 3) begin
            sonuc = vals[idx];
            exp_q.push_back(exps[idx]);
          end else begin
            giris_gecerli = 1'b0;
          end
        end
        if (cikis_gecerli) begin
          got = bcd;
          if (exp_q.size() == 0) begin
            check($sformatf("b2b_unexpected_out%0d", outs), {24'd0, got}, 64'd0);
          end else begin
            check($sformatf("b2b_out%0d_bcd", outs), {24'd0, got}, {24'd0, exp_q.pop_front()});
          end
          if (last_cyc >= 0)
            check($sformatf("b2b_out%0d_spacing", outs), 64'(cyc - last_cyc), 64'd34);
          last_cyc = cyc;
          outs++;
        end
        @(negedge clk);
      end
      check("b2b_output_count", 64'(outs), 64'd3);
      check("b2b_queue_empty", 64'(exp_q.size()), 64'd0);
      giris_gecerli = 1'b0;
      cikis_hazir = 1'b0;
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
